// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_CALC = 2'b10,
        ST_FIX  = 2'b11
    } md_state_e;

endpackage

// File: rtl/mul_div_unit_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step.
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opb_i,
    output logic [2*WIDTH-1:0]   acc_o
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] diff;

    // Multiply: acc = {partial product high, remaining multiplier bits}.
    assign sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opb_i} : '0);

    // Divide: acc = {remainder, dividend bits becoming quotient bits}.
    assign rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, opb_i};
    assign diff   = rem_sh[WIDTH-1:0] - opb_i;

    always_comb begin
        if (is_div_i)
            acc_o = {(ge ? diff : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
        else
            acc_o = {sum, acc_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [4:0] LAST = 5'(MD_ITERS - 1);

    md_state_e          state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod_fix;
    logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, done_q, done_d;
    logic               is_div, is_signed;
    logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign abs_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign abs_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    assign prod_fix  = neg_res_q ? -acc_q : acc_q;
    assign quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div),
        .acc_i    (acc_q),
        .opb_i    (opb_q),
        .acc_o    (step_acc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!cancel) begin
                        state_d = ST_PREP;
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                    end
                end else begin
                    if (mthi) hi_d = mt_data;
                    if (mtlo) lo_d = mt_data;
                end
            end
            ST_PREP: begin
                neg_res_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = is_signed & a_q[WIDTH-1];
                acc_d     = {{WIDTH{1'b0}}, abs_a};
                opb_d     = abs_b;
                cnt_d     = '0;
                state_d   = ST_CALC;
            end
            ST_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                // Divide by zero is resolved here rather than in the datapath so
                // the signed fix-up cannot disturb the fixed result.
                if (is_div && b_q == '0) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else if (is_div) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (cancel && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench: vector table plus scoreboard keyed on done.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, cancel = 1'b0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, mt_data = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
        .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [1:0] op; logic [31:0] a, b, hi, lo; } vec_t;
    typedef struct { logic [31:0] hi, lo; int k; } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Caller sits at a negedge; returns k = the edge that sampled start.
    task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int k);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = cyc;
    endtask

    task automatic go_exp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
        int k;
        exp_t e;
        go(o, x, y, k);
        e.hi = eh; e.lo = el; e.k = k;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'b0, busy}, 32'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want done=0 (cyc %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("res_hi", hi, mon_e.hi);
                check("res_lo", lo, mon_e.lo);
                check("latency", 32'(cyc - mon_e.k), 32'd34);
                check("busy_at_done", {31'b0, busy}, 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[11];
    int   k;
    logic [31:0] hsave, lsave;

    initial begin
        vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[5]  = '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[6]  = '{MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[7]  = '{MD_MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988};
        vecs[8]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[9]  = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0};
        vecs[10] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0};

        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            go_exp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
            wait_idle();
        end

        // Reset mid-operation clears everything immediately.
        go(MD_MULTU, 32'hFFFF, 32'hFFFF, k);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        go_exp(MD_MULTU, 32'd6, 32'd9, 32'd0, 32'd54);
        wait_idle();

        // MTHI/MTLO in IDLE, then both at once.
        mthi = 1'b1; mt_data = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi", hi, 32'h1234);
        mtlo = 1'b1; mt_data = 32'h5678;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo", lo, 32'h5678);
        check("mtlo_hi_kept", hi, 32'h1234);

        // Inputs held during busy are ignored.
        go_exp(MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
        start = 1'b1; op = MD_DIV; a = 32'hDEAD; b = 32'h5; mthi = 1'b1; mt_data = 32'hBEEF;
        repeat (20) @(negedge clk);
        check("busy_mid", {31'b0, busy}, 32'd1);
        check("mthi_ignored", hi, 32'h1234);
        start = 1'b0; mthi = 1'b0;
        wait_idle();

        mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hAAAA5555;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_both_hi", hi, 32'hAAAA5555);
        check("mt_both_lo", lo, 32'hAAAA5555);

        // Cancel during CALC.
        hsave = hi; lsave = lo;
        go(MD_MULTU, 32'd77, 32'd88, k);
        while (cyc < k + 20) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("cancel_hi", hi, hsave);
        check("cancel_lo", lo, lsave);

        // Cancel in FIX: no write, no done.
        go(MD_DIVU, 32'd1000, 32'd3, k);
        while (cyc < k + 33) @(negedge clk);
        check("fix_busy_before", {31'b0, busy}, 32'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("fixcancel_busy", {31'b0, busy}, 32'd0);
        check("fixcancel_hi", hi, hsave);
        check("fixcancel_lo", lo, lsave);
        repeat (3) @(negedge clk);

        // Start together with cancel in IDLE is dropped.
        start = 1'b1; cancel = 1'b1; op = MD_MULTU; a = 32'd2; b = 32'd2;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("startcancel_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("startcancel_lo", lo, lsave);

        // Back-to-back: second start issued in the done cycle.
        go_exp(MD_MULTU, 32'd11, 32'd13, 32'd0, 32'd143);
        begin
            int n = 0;
            while (!done && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("b2b_first_done", {31'b0, done}, 32'd1);
        go_exp(MD_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2);
        check("b2b_busy", {31'b0, busy}, 32'd1);
        wait_idle();
        repeat (2) @(negedge clk);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit in the EX stage, directly downstream of the register file. Consumes the two forwarded register-file read operands, computes MULT/MULTU/DIV/DIVU over 34 cycles, and holds results in the architectural HI/LO registers. The hazard logic stalls on `busy`. MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is verified.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `start`  in  1  launch operation; sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `cancel`  in  1  abort in-flight operation (pipeline flush)
- `a`  in  WIDTH  rs operand (multiplicand / dividend)
- `b`  in  WIDTH  rt operand (multiplier / divisor)
- `mthi`, `mtlo`  in  1  write `mt_data` to HI / LO
- `mt_data`  in  WIDTH  MTHI/MTLO data
- `busy`  out  1  operation in flight (registered)
- `done`  out  1  one-cycle pulse: HI/LO just updated by an operation
- `hi`, `lo`  out  WIDTH  architectural HI/LO

## Operation
- States:
  - IDLE: accepts `start`.
  - PREP: latch |a| and |b| for signed ops, raw a/b for unsigned ops; record the result signs.
  - CALC: 32 iterations, 5-bit counter.
  - FIX: apply signs, write HI/LO.
- Transitions:
  - IDLE→PREP on `start`.
  - PREP→CALC.
  - CALC→FIX when the counter reaches 31.
  - FIX→IDLE.
  - Any non-IDLE state→IDLE on `cancel`.
- `a`, `b` and `op` are captured at the `start` edge and are don't-care afterwards.
- Multiply:
  - Shift-add, one bit per CALC cycle, 64-bit product {HI,LO}.
  - Signed: negate the product iff the operand signs differ.
- Divide:
  - Restoring divide, one quotient bit per cycle; LO = quotient, HI = remainder.
  - Signed: negate the quotient iff the operand signs differ; the remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, with no special case.
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=a. Same latency.
- `mthi`/`mtlo` in IDLE without `start`: the register is written at the next edge. Both may be asserted in the same cycle.
- `mthi`/`mtlo` while busy, or in the same cycle as `start`: ignored (`start` has priority).
- `start` while busy: ignored.
- `cancel`:
  - Returns to IDLE at the next edge; `busy`=0, no `done`, HI/LO keep their prior values.
  - `cancel` with `start` in IDLE: `start` is dropped.
  - `cancel` in FIX: cancel wins; HI/LO are not written.
- Reset (any time, including mid-operation): state IDLE, counter 0, `busy`=0, `done`=0, `hi`=0, `lo`=0, all datapath registers 0.

## Timing
- `start` sampled at edge k:
  - `busy`=1 from edge k to edge k+34, i.e. 34 cycles.
  - CALC iterations at edges k+2..k+33.
  - HI/LO written and `done`=1 at edge k+34, for exactly one cycle.
  - `busy`=0 at edge k+34.
- Back-to-back: a new `start` is accepted in the cycle where `done`=1.
- MTHI/MTLO: visible on `hi`/`lo` one edge after assertion.
- `hi`/`lo` are registered and stable except at a write edge. No combinational path from inputs to any output.

## Structure
- Shared pipeline package holds:
  - op encodings (`MD_MULT`=2'b00, `MD_MULTU`=2'b01, `MD_DIV`=2'b10, `MD_DIVU`=2'b11);
  - the state encoding (IDLE/PREP/CALC/FIX);
  - `MD_ITERS`=32.
- One sub-module, `md_iter_step`: combinational single iteration.
  - Multiply: conditional add and shift.
  - Divide: trial subtract and shift.
  - Selected by a mul/div flag.
- The top holds the FSM, counter, operand/sign registers and HI/LO.

## Test plan
- Reset mid-op: MULTU started, `reset`=0 at cycle 10 → immediately `busy`=0, `done`=0, `hi`=`lo`=0; a new `start` after release completes normally.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → `done` at edge k+34, HI=0xFFFFFFFE, LO=0x00000001. MULT 0xFFFFFFFD×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 100/7 → LO=14, HI=2.
- DIVU 5/0 and DIV 0xFFFFFFFB/0 → LO=0xFFFFFFFF, HI=a; still 34-cycle latency.
- MTHI 0x1234 then MTLO 0x5678 in IDLE → visible next edge. Then:
  - MULTU 3×4 launched; `start`, `mthi` and changed a/b held during busy are all ignored.
  - Result HI=0, LO=12.
- Cancel: `cancel` at edge k+20 → `busy`=0 at k+21, no `done`, HI/LO unchanged. Cancel in FIX → no write. Back-to-back `start` on the `done` cycle is accepted.
